// File: rtl/dmem_wb_stage.sv
// Byte-addressed data memory with sub-word load/store and alignment check, feeding the MEM/WB register.
// Latency: mdo combinational, W outputs 1 cycle; stall holds MEM/WB and blocks the store, flush bubbles WB only.
module dmem_wb_stage #(
    parameter int DEPTH  = 64,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic              mrmem,
    input  logic [1:0]        msize,
    input  logic              munsigned,
    input  logic [DEST_W-1:0] mdestReg,
    input  logic [31:0]       mr,
    input  logic [31:0]       mqb,
    output logic [31:0]       mdo,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DEST_W-1:0] wdestReg,
    output logic [31:0]       wr,
    output logic [31:0]       wdo,
    output logic              wexc
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DEST_W-1:0] dest;
        logic [31:0]       r;
        logic [31:0]       dat;
        logic              exc;
    } wb_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          acc;
    logic          mis;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    wb_t           wb_q;
    wb_t           wb_nxt;

    // Upper address bits are dropped, so accesses wrap modulo 4*DEPTH bytes.
    assign widx = mr[AW+1:2];
    assign lane = mr[1:0];
    assign acc  = mwmem | mrmem;

    always_comb begin
        case (msize)
            2'd0:    mis = 1'b0;
            2'd1:    mis = acc & mr[0];
            default: mis = acc & (mr[1:0] != 2'd0);
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        case (msize)
            2'd0: begin
                be   = 4'b0001 << lane;
                wdat = {4{mqb[7:0]}};
            end
            2'd1: begin
                be   = mr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{mqb[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = mqb;
            end
        endcase
    end

    assign wr_en = mwmem & ~mis & ~stall & ~rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdat[8*i +: 8];
                end
            end
        end
    end

    // Read is asynchronous, so a same-cycle store shows up only after its edge.
    assign rword = mem[widx];
    assign rbyte = rword[{lane, 3'b000} +: 8];
    assign rhalf = mr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        if (mis) begin
            mdo = 32'd0;
        end else begin
            case (msize)
                2'd0:    mdo = {{24{~munsigned & rbyte[7]}}, rbyte};
                2'd1:    mdo = {{16{~munsigned & rhalf[15]}}, rhalf};
                default: mdo = rword;
            endcase
        end
    end

    always_comb begin
        wb_nxt       = '0;
        wb_nxt.wreg  = mwreg & ~mis;
        wb_nxt.m2reg = mm2reg;
        wb_nxt.dest  = mdestReg;
        wb_nxt.r     = mr;
        wb_nxt.dat   = mdo;
        wb_nxt.exc   = mis;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q <= '0;
        end else if (!stall) begin
            wb_q <= wb_nxt;
        end
    end

    assign wwreg    = wb_q.wreg;
    assign wm2reg   = wb_q.m2reg;
    assign wdestReg = wb_q.dest;
    assign wr       = wb_q.r;
    assign wdo      = wb_q.dat;
    assign wexc     = wb_q.exc;

endmodule

// File: tb/tb_dmem_wb_stage.sv
// Bench for dmem_wb_stage: table of per-cycle vectors, WB expectations queued and checked one edge later.
module tb_dmem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, mwreg, mm2reg, mwmem, mrmem, munsigned;
    logic [1:0]  msize;
    logic [4:0]  mdestReg, wdestReg;
    logic [31:0] mr, mqb, mdo, wr, wdo;
    logic        wwreg, wm2reg, wexc;

    always #5 clk = ~clk;

    dmem_wb_stage #(.DEPTH(64), .DEST_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mrmem(mrmem),
        .msize(msize), .munsigned(munsigned), .mdestReg(mdestReg),
        .mr(mr), .mqb(mqb), .mdo(mdo),
        .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg),
        .wr(wr), .wdo(wdo), .wexc(wexc)
    );

    typedef struct {
        bit        rst, stall, flush, wreg, m2reg, wmem, rmem, uns;
        bit [1:0]  size;
        bit [4:0]  dest;
        bit [31:0] addr, data, e_mdo;
        bit        e_exc;
    } vec_t;

    typedef struct packed {
        logic        wwreg;
        logic        wm2reg;
        logic [4:0]  dest;
        logic [31:0] wr;
        logic [31:0] wdo;
        logic        wexc;
    } wb_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    wb_t  sb[$];
    wb_t  last = '0;
    vec_t tbl[$];

    function automatic vec_t mk(bit wreg, bit m2reg, bit wmem, bit rmem, bit [1:0] size,
                                bit uns, bit [4:0] dest, bit [31:0] addr, bit [31:0] data,
                                bit [31:0] e_mdo, bit e_exc);
        vec_t v;
        v.rst = 0; v.stall = 0; v.flush = 0;
        v.wreg = wreg; v.m2reg = m2reg; v.wmem = wmem; v.rmem = rmem;
        v.size = size; v.uns = uns; v.dest = dest; v.addr = addr; v.data = data;
        v.e_mdo = e_mdo; v.e_exc = e_exc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(string tag, vec_t v);
        wb_t e;
        @(negedge clk);
        rst = v.rst; stall = v.stall; flush = v.flush;
        mwreg = v.wreg; mm2reg = v.m2reg; mwmem = v.wmem; mrmem = v.rmem;
        msize = v.size; munsigned = v.uns; mdestReg = v.dest; mr = v.addr; mqb = v.data;
        #1;
        chk({tag, ".mdo"}, mdo, v.e_mdo);
        if (v.rst || v.flush) begin
            e = '0;
        end else if (v.stall) begin
            e = last;
        end else begin
            e.wwreg  = v.wreg & ~v.e_exc;
            e.wm2reg = v.m2reg;
            e.dest   = v.dest;
            e.wr     = v.addr;
            e.wdo    = v.e_mdo;
            e.wexc   = v.e_exc;
        end
        last = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL %s.sb: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".wwreg"},    wwreg,    e.wwreg);
            chk({tag, ".wm2reg"},   wm2reg,   e.wm2reg);
            chk({tag, ".wdestReg"}, wdestReg, e.dest);
            chk({tag, ".wr"},       wr,       e.wr);
            chk({tag, ".wdo"},      wdo,      e.wdo);
            chk({tag, ".wexc"},     wexc,     e.wexc);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1; stall = 0; flush = 0; mwreg = 0; mm2reg = 0; mwmem = 0; mrmem = 0;
        msize = 0; munsigned = 0; mdestReg = 0; mr = 0; mqb = 0;

        v = mk(0,0,0,0,0,0,0,  32'h0,   32'h0,        32'h0,        0); v.rst = 1; tbl.push_back(v);
        tbl.push_back(mk(0,0,1,0,2,0,0,  32'h10,  32'hCAFEF00D, 32'h0,        0));
        v = mk(1,0,1,0,2,0,3,  32'h10,  32'h0BADBEEF, 32'hCAFEF00D, 0); v.rst = 1; tbl.push_back(v);
        v = mk(1,1,0,1,2,0,5,  32'h33,  32'h0,        32'h0,        1); v.rst = 1; tbl.push_back(v);
        tbl.push_back(mk(1,1,0,1,2,0,4,  32'h10,  32'h0,        32'hCAFEF00D, 0));
        tbl.push_back(mk(0,0,1,0,2,0,0,  32'h20,  32'h11223344, 32'h0,        0));
        tbl.push_back(mk(0,0,1,0,0,0,0,  32'h21,  32'h123456AA, 32'h00000033, 0));
        tbl.push_back(mk(1,1,0,1,2,0,6,  32'h20,  32'h0,        32'h1122AA44, 0));
        tbl.push_back(mk(1,1,0,1,0,0,7,  32'h21,  32'h0,        32'hFFFFFFAA, 0));
        tbl.push_back(mk(1,1,0,1,0,1,7,  32'h21,  32'h0,        32'h000000AA, 0));
        tbl.push_back(mk(1,1,0,1,1,0,8,  32'h22,  32'h0,        32'h00001122, 0));
        tbl.push_back(mk(1,1,0,1,1,0,8,  32'h20,  32'h0,        32'hFFFFAA44, 0));
        tbl.push_back(mk(1,1,0,1,1,1,8,  32'h20,  32'h0,        32'h0000AA44, 0));
        tbl.push_back(mk(1,1,0,1,0,0,2,  32'h23,  32'h0,        32'h00000011, 0));
        tbl.push_back(mk(1,0,1,0,2,0,8,  32'h22,  32'hFFFFFFFF, 32'h0,        1));
        tbl.push_back(mk(1,1,0,1,2,0,6,  32'h20,  32'h0,        32'h1122AA44, 0));
        tbl.push_back(mk(1,1,0,1,1,0,9,  32'h21,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0,0,1,0,1,0,0,  32'h22,  32'h0000BEEF, 32'h00001122, 0));
        tbl.push_back(mk(1,1,0,1,2,0,6,  32'h20,  32'h0,        32'hBEEFAA44, 0));
        v = mk(1,1,0,1,2,0,9,  32'h20,  32'h0,        32'hBEEFAA44, 0); v.flush = 1; tbl.push_back(v);
        v = mk(1,0,1,0,2,0,10, 32'h24,  32'h77,       32'h0,        0); v.flush = 1; v.stall = 1; tbl.push_back(v);
        tbl.push_back(mk(1,1,0,1,2,0,10, 32'h24,  32'h0,        32'h0,        0));
        v = mk(1,0,1,0,2,0,11, 32'h28,  32'h99,       32'h0,        0); v.flush = 1; tbl.push_back(v);
        tbl.push_back(mk(1,1,0,1,2,0,11, 32'h28,  32'h0,        32'h99,       0));
        tbl.push_back(mk(0,0,1,0,2,0,0,  32'h100, 32'h55,       32'h0,        0));
        tbl.push_back(mk(1,1,0,1,2,0,12, 32'h0,   32'h0,        32'h55,       0));
        tbl.push_back(mk(1,1,0,1,3,0,12, 32'h28,  32'h0,        32'h99,       0));
        tbl.push_back(mk(1,1,0,1,3,0,13, 32'h2A,  32'h0,        32'h0,        1));
        tbl.push_back(mk(1,0,0,0,2,0,14, 32'h23,  32'h0,        32'hBEEFAA44, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("r%0d", i), tbl[i]);
        end

        // Stalled store: WB holds, memory untouched until stall drops, then one write.
        for (int i = 0; i < 3; i++) begin
            v = mk(1,0,1,0,2,0,7, 32'h40, 32'hDEADBEEF, 32'h0, 0);
            v.stall = 1;
            step($sformatf("stall%0d", i), v);
        end
        step("unstall", mk(1,0,1,0,2,0,7,  32'h40, 32'hDEADBEEF, 32'h0,        0));
        step("ld40",    mk(1,1,0,1,2,0,15, 32'h40, 32'h0,        32'hDEADBEEF, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
